// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter for the data memory bus with bus lock and lock timeout
module dmem_arbiter #(
  parameter int LOCK_TIMEOUT = 16,
  parameter int TW = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        locked,
  output logic        lock_owner
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic last_winner, cur, c_we;
  logic [31:0] c_addr, c_wdata;
  logic [TW-1:0] cnt;
  logic e0, e1, any, win, owner_req, tick;
  always_comb begin
    e0 = m0_req & (~locked | ~lock_owner);
    e1 = m1_req & (~locked | lock_owner);
    any = e0 | e1;
    win = (e0 & e1) ? ~last_winner : e1;
    owner_req = lock_owner ? m1_req : m0_req;
    tick = cnt == TW'(LOCK_TIMEOUT - 1);
    state_n = state == IDLE ? (any ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
    m0_gnt = state == ACCESS && !cur;
    m1_gnt = state == ACCESS && cur;
    m0_rvalid = state == RESP && !cur;
    m1_rvalid = state == RESP && cur;
    mem_read = state == ACCESS && !c_we;
    mem_write = state == ACCESS && c_we;
    mem_addr = state == ACCESS ? c_addr : '0;
    mem_wdata = state == ACCESS ? c_wdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_winner <= 1'b1;
      cur <= 1'b0;
      c_we <= 1'b0;
      c_addr <= '0;
      c_wdata <= '0;
      locked <= 1'b0;
      lock_owner <= 1'b0;
      cnt <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any) begin
        cur <= win;
        last_winner <= win;
        c_we <= win ? m1_we : m0_we;
        c_addr <= win ? m1_addr : m0_addr;
        c_wdata <= win ? m1_wdata : m0_wdata;
        locked <= win ? m1_lock : m0_lock;
        lock_owner <= win;
        cnt <= '0;
      end else if (state == IDLE && locked && !owner_req) begin
        // idle owner: count toward forced release
        locked <= ~tick;
        cnt <= tick ? '0 : cnt + 1'b1;
      end
      if (state == ACCESS && !cur) m0_rdata <= c_we ? '0 : mem_rdata;
      if (state == ACCESS && cur) m1_rdata <= c_we ? '0 : mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table plus scoreboard bench for dmem_arbiter with a behavioural RAM
module tb_dmem_arbiter;
  localparam int LT = 16;
  logic clk = 0, rst = 1;
  logic m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_read, mem_write, locked, lock_owner;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  always #5 clk = ~clk;
  dmem_arbiter #(.LOCK_TIMEOUT(LT), .TW(5)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .locked(locked), .lock_owner(lock_owner)
  );
  typedef struct {logic we; logic lock; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rd;} item_t;
  typedef struct {int p; item_t it;} exp_t;
  exp_t q[$];
  int nchk = 0, nerr = 0, cyc = 0;
  int gl[$], rl[$];
  logic [1:0] lk[$];
  logic [31:0] last_rd[2] = '{default: '0};
  logic [31:0] ram[256];
  bit ram_init = 0;
  wire [135:0] outs = {m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
                       mem_read, mem_write, mem_addr, mem_wdata, locked, lock_owner};
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h1000_0000 + i;
      ram[16] <= 32'hDEADBEEF;
      ram_init <= 1;
    end else if (mem_write) ram[mem_addr[9:2]] <= mem_wdata;
  end
  assign mem_rdata = ram[mem_addr[9:2]];
  task automatic chk(input string n, input logic [159:0] a, input logic [159:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (m0_gnt | m1_gnt) begin
        chk("gnt_onehot", 160'(m0_gnt & m1_gnt), 160'(0));
        gl.push_back(cyc);
        if (q.size() == 0) chk("unexpected_gnt", 160'(1), 160'(0));
        else begin
          e = q[0];
          chk("gnt_port", 160'(m1_gnt), 160'(e.p));
          chk("mem_rw", 160'({mem_read, mem_write}), 160'({~e.it.we, e.it.we}));
          chk("mem_addr", 160'(mem_addr), 160'(e.it.addr));
          if (e.it.we) chk("mem_wdata", 160'(mem_wdata), 160'(e.it.wdata));
        end
      end else chk("bus_idle", 160'({mem_read, mem_write, mem_addr, mem_wdata}), 160'(0));
      if (m0_rvalid | m1_rvalid) begin
        rl.push_back(cyc);
        lk.push_back({locked, lock_owner});
        if (q.size() == 0 || gl.size() == 0) chk("unexpected_rvalid", 160'(1), 160'(0));
        else begin
          e = q.pop_front();
          chk("rvalid_port", 160'(m1_rvalid), 160'(e.p));
          chk("rvalid_onehot", 160'(m0_rvalid & m1_rvalid), 160'(0));
          chk("rvalid_lat", 160'(cyc - gl[gl.size()-1]), 160'(1));
          chk("rdata", 160'(e.p != 0 ? m1_rdata : m0_rdata), 160'(e.it.rd));
          chk("other_rdata", 160'(e.p != 0 ? m0_rdata : m1_rdata), 160'(last_rd[1-e.p]));
          last_rd[e.p] = e.it.rd;
        end
      end
    end
  end
  task automatic set_port(input int p, input item_t it, input logic r);
    if (p == 0) begin
      m0_req = r; m0_we = it.we; m0_lock = it.lock; m0_addr = it.addr; m0_wdata = it.wdata;
    end else begin
      m1_req = r; m1_we = it.we; m1_lock = it.lock; m1_addr = it.addr; m1_wdata = it.wdata;
    end
  endtask
  task automatic push(input int p, input item_t it);
    exp_t e;
    e.p = p;
    e.it = it;
    q.push_back(e);
  endtask
  task automatic drive_port(input int p, input item_t l[$]);
    bit got;
    item_t z;
    z = '{default: '0};
    foreach (l[i]) begin
      got = 0;
      set_port(p, l[i], 1);
      for (int k = 0; k < 100 && !got; k++) begin
        @(negedge clk);
        got = p != 0 ? m1_gnt : m0_gnt;
      end
      if (!got) begin
        chk("gnt_timeout", 160'(0), 160'(1));
        set_port(p, z, 0);
        return;
      end
      @(posedge clk); #1;
    end
    set_port(p, z, 0);
  endtask
  task automatic drain();
    for (int k = 0; k < 30 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      chk("drain", 160'(q.size()), 160'(0));
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1; m0_req = 0; m1_req = 0;
    q.delete();
    last_rd = '{default: '0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_zero", 160'(outs), 160'(0));
    rst = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    exp_t tbl[7];
    item_t one[$], la[$], lb[$];
    bit got;
    tbl[0] = '{0, '{0, 0, 32'h40, 32'h0, 32'hDEADBEEF}};
    tbl[1] = '{1, '{1, 0, 32'h80, 32'h12345678, 32'h0}};
    tbl[2] = '{0, '{0, 0, 32'h80, 32'h0, 32'h12345678}};
    tbl[3] = '{1, '{0, 0, 32'h40, 32'h0, 32'hDEADBEEF}};
    tbl[4] = '{0, '{1, 0, 32'h44, 32'hA5A5A5A5, 32'h0}};
    tbl[5] = '{1, '{0, 0, 32'h44, 32'h0, 32'hA5A5A5A5}};
    tbl[6] = '{0, '{0, 0, 32'hFFFFFFFC, 32'h0, 32'h100000FF}};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      push(tbl[i].p, tbl[i].it);
      one.delete();
      one.push_back(tbl[i].it);
      drive_port(tbl[i].p, one);
      drain();
    end
    // contention straight after reset: m0 first, then strict alternation
    do_reset();
    gl.delete();
    la = '{'{1, 0, 32'h300, 32'h11, 32'h0}, '{0, 0, 32'h40, 32'h0, 32'hDEADBEEF}};
    lb = '{'{0, 0, 32'h300, 32'h0, 32'h11}, '{1, 0, 32'h304, 32'h22, 32'h0}};
    push(0, la[0]); push(1, lb[0]); push(0, la[1]); push(1, lb[1]);
    fork
      drive_port(0, la);
      drive_port(1, lb);
    join
    drain();
    if (gl.size() < 4) chk("rr_gnt_count", 160'(gl.size()), 160'(4));
    else for (int i = 0; i < 3; i++) chk("rr_spacing", 160'(gl[i+1] - gl[i]), 160'(3));
    // lock held across a read-modify-write keeps m1 out
    do_reset();
    lk.delete();
    la = '{'{0, 1, 32'h100, 32'h0, 32'h10000040}, '{1, 0, 32'h100, 32'hCAFEF00D, 32'h0}};
    lb = '{'{0, 0, 32'h100, 32'h0, 32'hCAFEF00D}};
    push(0, la[0]); push(0, la[1]); push(1, lb[0]);
    fork
      drive_port(0, la);
      drive_port(1, lb);
    join
    drain();
    if (lk.size() < 3) chk("lock_log", 160'(lk.size()), 160'(3));
    else begin
      chk("lock_set", 160'(lk[0]), 160'(2'b10));
      chk("lock_released", 160'(lk[1]), 160'(2'b00));
    end
    // lock timeout releases the bus to the waiting port
    do_reset();
    gl.delete(); rl.delete(); lk.delete();
    la = '{'{0, 1, 32'h40, 32'h0, 32'hDEADBEEF}};
    lb = '{'{0, 0, 32'h80, 32'h0, 32'h12345678}};
    push(0, la[0]); push(1, lb[0]);
    fork
      drive_port(0, la);
      begin
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
          @(negedge clk);
          got = m0_gnt;
        end
        @(posedge clk); #1;
        drive_port(1, lb);
      end
    join
    drain();
    if (gl.size() < 2 || rl.size() < 1 || lk.size() < 1) chk("timeout_log", 160'(gl.size()), 160'(2));
    else begin
      chk("timeout_gap", 160'(gl[1] - rl[0]), 160'(LT + 2));
      chk("timeout_locked", 160'(lk[0]), 160'(2'b10));
    end
    // reset during ACCESS of a write drops it
    do_reset();
    one.delete();
    one.push_back('{1, 0, 32'h200, 32'h55AA55AA, 32'h0});
    push(0, one[0]);
    set_port(0, one[0], 1);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = m0_gnt;
    end
    chk("mid_gnt_seen", 160'(got), 160'(1));
    #1;
    rst = 1; m0_req = 0;
    @(posedge clk);
    q.delete();
    last_rd = '{default: '0};
    @(negedge clk);
    chk("reset_mid_zero", 160'(outs), 160'(0));
    rst = 0;
    repeat (4) @(negedge clk);
    la = '{'{0, 0, 32'h40, 32'h0, 32'hDEADBEEF}};
    lb = '{'{0, 0, 32'h44, 32'h0, 32'hA5A5A5A5}};
    push(0, la[0]); push(1, lb[0]);
    fork
      drive_port(0, la);
      drive_port(1, lb);
    join
    drain();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
